// File: rtl/dom_ori_hist_7x7.sv
// Dominant-orientation finder for a 7x7 window of angles: 36-bin histogram, then linear argmax scan.
// Optional macro DOM_ORI_CLAMP_EN: out-of-range angles (360..511) land in bin 35 instead of being dropped.
module dom_ori_hist_7x7 (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       ivalid,
    input  logic [8:0] idata0,
    input  logic [8:0] idata1,
    input  logic [8:0] idata2,
    input  logic [8:0] idata3,
    input  logic [8:0] idata4,
    input  logic [8:0] idata5,
    input  logic [8:0] idata6,
    output logic       obusy,
    output logic       ovalid,
    output logic [8:0] oorient,
    output logic [5:0] ocount
);

    typedef enum logic [1:0] {IDLE, ACCUM, SEARCH, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_colCnt;
    logic [5:0]  r_scanIdx;
    logic [5:0]  r_hist [36];
    logic [5:0]  r_maxCnt;
    logic [5:0]  r_maxBin;
    logic [8:0]  r_oorient;
    logic [5:0]  r_ocount;

    logic [8:0]  w_angle [7];
    logic [5:0]  w_bin   [7];
    logic        w_binOk [7];
    logic [2:0]  w_inc   [36];
    logic        w_accept;
    logic        w_lastCol;
    logic        w_scanEnd;
    logic [5:0]  w_scanCnt;

    assign w_angle[0] = idata0;
    assign w_angle[1] = idata1;
    assign w_angle[2] = idata2;
    assign w_angle[3] = idata3;
    assign w_angle[4] = idata4;
    assign w_angle[5] = idata5;
    assign w_angle[6] = idata6;

    assign w_accept  = ivalid && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_lastCol = (r_colCnt == 3'd6);
    assign w_scanEnd = (r_scanIdx == 6'd36);
    assign w_scanCnt = w_scanEnd ? 6'd0 : r_hist[r_scanIdx];

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_binOk[k] = 1'b1;
            w_bin[k]   = 6'(w_angle[k] / 9'd10);
            if (w_angle[k] >= 9'd360) begin
`ifdef DOM_ORI_CLAMP_EN
                w_bin[k]   = 6'd35;
`else
                w_binOk[k] = 1'b0;
                w_bin[k]   = 6'd0;
`endif
            end
        end
    end

    // Per-bin increment for the incoming column (0..7 hits per bin).
    always_comb begin
        for (int b = 0; b < 36; b++) begin
            w_inc[b] = 3'd0;
            for (int k = 0; k < 7; k++) begin
                if (w_binOk[k] && (w_bin[k] == 6'(b))) begin
                    w_inc[b] = w_inc[b] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = ACCUM;
            ACCUM:   if (w_accept && w_lastCol) w_nextState = SEARCH;
            SEARCH:  if (w_scanEnd) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        obusy  = (r_state == SEARCH) || (r_state == DONE);
        ovalid = (r_state == DONE);
    end

    always_ff @(posedge iclk) begin
        if (!irst_n || (r_state == DONE)) begin
            for (int b = 0; b < 36; b++) begin
                r_hist[b] <= 6'd0;
            end
        end else if (w_accept) begin
            for (int b = 0; b < 36; b++) begin
                r_hist[b] <= r_hist[b] + 6'(w_inc[b]);
            end
        end
    end

    // The scan spends one extra cycle at index 36 to latch the final maximum into the outputs.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_colCnt  <= 3'd0;
            r_scanIdx <= 6'd0;
            r_maxCnt  <= 6'd0;
            r_maxBin  <= 6'd0;
            r_oorient <= 9'd0;
            r_ocount  <= 6'd0;
        end else begin
            if (w_accept) begin
                r_colCnt <= w_lastCol ? 3'd0 : r_colCnt + 3'd1;
            end
            if (r_state == SEARCH) begin
                if (!w_scanEnd) begin
                    if (w_scanCnt > r_maxCnt) begin
                        r_maxCnt <= w_scanCnt;
                        r_maxBin <= r_scanIdx;
                    end
                    r_scanIdx <= r_scanIdx + 6'd1;
                end else begin
                    r_oorient <= 9'(r_maxBin) * 9'd10;
                    r_ocount  <= r_maxCnt;
                end
            end
            if (r_state == DONE) begin
                r_scanIdx <= 6'd0;
                r_maxCnt  <= 6'd0;
                r_maxBin  <= 6'd0;
            end
        end
    end

    assign oorient = r_oorient;
    assign ocount  = r_ocount;

endmodule

// File: tb/tb_dom_ori_hist_7x7.sv
// Randomized self-checking bench for dom_ori_hist_7x7 against a plain histogram/argmax model.
module tb_dom_ori_hist_7x7;

    logic       clk = 1'b0;
    logic       irst_n = 1'b0;
    logic       ivalid = 1'b0;
    logic [8:0] idata [7];
    logic       obusy;
    logic       ovalid;
    logic [8:0] oorient;
    logic [5:0] ocount;

    logic [8:0] win [7][7];
    int         tests = 0;
    int         fails = 0;
    int         pulses = 0;

    dom_ori_hist_7x7 dut (
        .iclk    (clk),
        .irst_n  (irst_n),
        .ivalid  (ivalid),
        .idata0  (idata[0]),
        .idata1  (idata[1]),
        .idata2  (idata[2]),
        .idata3  (idata[3]),
        .idata4  (idata[4]),
        .idata5  (idata[5]),
        .idata6  (idata[6]),
        .obusy   (obusy),
        .ovalid  (ovalid),
        .oorient (oorient),
        .ocount  (ocount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ovalid === 1'b1) pulses <= pulses + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: count every angle into bin angle/10, then take the first bin holding the maximum.
    function automatic void model(output int eOri, output int eCnt);
        int h [36];
        int best;
        foreach (h[b]) h[b] = 0;
        for (int c = 0; c < 7; c++) begin
            for (int t = 0; t < 7; t++) begin
                int a;
                a = int'(win[c][t]);
                if (a < 360) h[a / 10]++;
`ifdef DOM_ORI_CLAMP_EN
                else h[35]++;
`endif
            end
        end
        best = 0;
        for (int b = 1; b < 36; b++) if (h[b] > h[best]) best = b;
        eOri = best * 10;
        eCnt = h[best];
    endfunction

    task automatic randomData();
        for (int t = 0; t < 7; t++) idata[t] = 9'($urandom_range(0, 511));
    endtask

    task automatic fillAll(input int a);
        for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++) win[c][t] = 9'(a);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        irst_n = 1'b0;
        ivalid = 1'b1;
        randomData();
        @(negedge clk);
        irst_n = 1'b1;
        ivalid = 1'b0;
        checkOutput({tag, "_busy"}, int'(obusy), 0);
        checkOutput({tag, "_ovalid"}, int'(ovalid), 0);
        checkOutput({tag, "_orient"}, int'(oorient), 0);
        checkOutput({tag, "_count"}, int'(ocount), 0);
    endtask

    task automatic applyStimulus(input int nCols, input bit gaps);
        for (int c = 0; c < nCols; c++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    ivalid = 1'b0;
                    randomData();
                end
            end
            @(negedge clk);
            ivalid = 1'b1;
            for (int t = 0; t < 7; t++) idata[t] = win[c][t];
        end
    endtask

    task automatic waitResult(input string tag, input bit noisy);
        int eOri, eCnt, cyc, p0;
        bit seen;
        model(eOri, eCnt);
        p0 = pulses;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) checkOutput({tag, "_busy"}, int'(obusy), 1);
            if (ovalid === 1'b1) seen = 1'b1;
            else if (noisy) begin
                ivalid = 1'($urandom_range(0, 1));
                randomData();
            end else ivalid = 1'b0;
        end
        ivalid = 1'b0;
        checkOutput({tag, "_seen"}, int'(seen), 1);
        checkOutput({tag, "_latency"}, cyc, 38);
        checkOutput({tag, "_orient"}, int'(oorient), eOri);
        checkOutput({tag, "_count"}, int'(ocount), eCnt);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, int'(ovalid), 0);
        checkOutput({tag, "_idle"}, int'(obusy), 0);
        checkOutput({tag, "_npulse"}, pulses - p0, 1);
        checkOutput({tag, "_hold"}, int'(oorient), eOri);
    endtask

    initial begin
        int p0;
        randomData();
        doReset("reset");

        fillAll(45);
        applyStimulus(7, 1'b0);
        waitResult("all45", 1'b0);

        for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++) win[c][t] = (t < 3) ? 9'd0 : 9'd100;
        applyStimulus(7, 1'b0);
        waitResult("mix100", 1'b0);

        applyStimulus(7, 1'b1);
        waitResult("gaps", 1'b1);

        for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++)
            win[c][t] = (t < 3) ? 9'd35 : (t < 6) ? 9'd200 : 9'(50 + 10 * c);
        applyStimulus(7, 1'b0);
        waitResult("tie", 1'b0);

        for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++) win[c][t] = 9'($urandom_range(0, 511));
        p0 = pulses;
        applyStimulus(4, 1'b0);
        doReset("rstAccum");
        fillAll(200);
        applyStimulus(7, 1'b0);
        waitResult("after_rst", 1'b0);
        checkOutput("rstAccum_pulses", pulses - p0, 1);

        for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++) win[c][t] = 9'($urandom_range(0, 359));
        p0 = pulses;
        applyStimulus(7, 1'b0);
        repeat (10) begin
            @(negedge clk);
            ivalid = 1'b0;
        end
        doReset("rstSearch");
        repeat (50) @(negedge clk);
        checkOutput("rstSearch_pulses", pulses - p0, 0);

        fillAll(400);
        applyStimulus(7, 1'b0);
        waitResult("clamp400", 1'b0);

        for (int r = 0; r < 6; r++) begin
            int lo, hi;
            lo = $urandom_range(0, 300);
            hi = (r % 2 == 0) ? lo + 40 : 511;
            for (int c = 0; c < 7; c++) for (int t = 0; t < 7; t++) win[c][t] = 9'($urandom_range(lo, hi));
            applyStimulus(7, r[0]);
            waitResult($sformatf("rand%0d", r), r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
